// File: rtl/dual_mode_peak_tracker.sv
// Dual-mode peak tracker: scans a run of len samples and reports the largest and
// smallest value with their first positions, comparing as signed or unsigned.
module dual_mode_peak_tracker #(
  parameter int unsigned W  = 8,
  parameter int unsigned LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [LW-1:0] len,
  input  logic [W-1:0]  din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [W-1:0]  max_val,
  output logic [W-1:0]  min_val,
  output logic [LW-1:0] max_idx,
  output logic [LW-1:0] min_idx,
  output logic          busy,
  output logic          done_tick,
  output logic          empty
);

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  state_e        state_q, state_d;

  // Run configuration latched at start
  logic          mode_q, mode_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;

  // Running extrema for the run in progress
  logic [W-1:0]  run_max_q, run_max_d;
  logic [W-1:0]  run_min_q, run_min_d;
  logic [LW-1:0] run_max_idx_q, run_max_idx_d;
  logic [LW-1:0] run_min_idx_q, run_min_idx_d;

  // Registered outputs; results only change when a run reaches DONE
  logic          din_ready_q, din_ready_d;
  logic          busy_q, busy_d;
  logic          done_tick_q, done_tick_d;
  logic          empty_q, empty_d;
  logic [W-1:0]  max_val_q, max_val_d;
  logic [W-1:0]  min_val_q, min_val_d;
  logic [LW-1:0] max_idx_q, max_idx_d;
  logic [LW-1:0] min_idx_q, min_idx_d;

  // Signed compare is done as unsigned after flipping the sign bit
  logic [W-1:0]  sign_flip;
  logic [W-1:0]  din_key, max_key, min_key;
  logic          accept, first, last;
  logic          new_max, new_min;
  logic [W-1:0]  upd_max, upd_min;
  logic [LW-1:0] upd_max_idx, upd_min_idx;

  assign sign_flip = {mode_q, {(W-1){1'b0}}};
  assign din_key   = din ^ sign_flip;
  assign max_key   = run_max_q ^ sign_flip;
  assign min_key   = run_min_q ^ sign_flip;

  // din_ready_q is high exactly while in ACTIVE
  assign accept = din_ready_q & din_valid;
  assign first  = (cnt_q == '0);
  assign last   = (cnt_q == len_q - LW'(1));

  // Strict compares keep the earlier index on ties
  assign new_max = first | (din_key > max_key);
  assign new_min = first | (din_key < min_key);

  assign upd_max     = new_max ? din   : run_max_q;
  assign upd_min     = new_min ? din   : run_min_q;
  assign upd_max_idx = new_max ? cnt_q : run_max_idx_q;
  assign upd_min_idx = new_min ? cnt_q : run_min_idx_q;

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    run_max_d     = run_max_q;
    run_min_d     = run_min_q;
    run_max_idx_d = run_max_idx_q;
    run_min_idx_d = run_min_idx_q;
    din_ready_d   = din_ready_q;
    busy_d        = busy_q;
    done_tick_d   = 1'b0;
    empty_d       = empty_q;
    max_val_d     = max_val_q;
    min_val_d     = min_val_q;
    max_idx_d     = max_idx_q;
    min_idx_d     = min_idx_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            mode_d      = mode;
            len_d       = len;
            cnt_d       = '0;
            din_ready_d = 1'b1;
            busy_d      = 1'b1;
            state_d     = StActive;
          end else begin
            // Zero-length run completes immediately with cleared results
            done_tick_d = 1'b1;
            empty_d     = 1'b1;
            max_val_d   = '0;
            min_val_d   = '0;
            max_idx_d   = '0;
            min_idx_d   = '0;
            state_d     = StDone;
          end
        end
      end

      StActive: begin
        if (accept) begin
          run_max_d     = upd_max;
          run_min_d     = upd_min;
          run_max_idx_d = upd_max_idx;
          run_min_idx_d = upd_min_idx;
          if (last) begin
            // Publish the final extrema together with the move to DONE
            din_ready_d = 1'b0;
            busy_d      = 1'b0;
            done_tick_d = 1'b1;
            empty_d     = 1'b0;
            max_val_d   = upd_max;
            min_val_d   = upd_min;
            max_idx_d   = upd_max_idx;
            min_idx_d   = upd_min_idx;
            state_d     = StDone;
          end else begin
            cnt_d = cnt_q + LW'(1);
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        din_ready_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      mode_q        <= 1'b0;
      len_q         <= '0;
      cnt_q         <= '0;
      run_max_q     <= '0;
      run_min_q     <= '0;
      run_max_idx_q <= '0;
      run_min_idx_q <= '0;
      din_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_tick_q   <= 1'b0;
      empty_q       <= 1'b0;
      max_val_q     <= '0;
      min_val_q     <= '0;
      max_idx_q     <= '0;
      min_idx_q     <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      run_max_q     <= run_max_d;
      run_min_q     <= run_min_d;
      run_max_idx_q <= run_max_idx_d;
      run_min_idx_q <= run_min_idx_d;
      din_ready_q   <= din_ready_d;
      busy_q        <= busy_d;
      done_tick_q   <= done_tick_d;
      empty_q       <= empty_d;
      max_val_q     <= max_val_d;
      min_val_q     <= min_val_d;
      max_idx_q     <= max_idx_d;
      min_idx_q     <= min_idx_d;
    end
  end

  assign din_ready = din_ready_q;
  assign busy      = busy_q;
  assign done_tick = done_tick_q;
  assign empty     = empty_q;
  assign max_val   = max_val_q;
  assign min_val   = min_val_q;
  assign max_idx   = max_idx_q;
  assign min_idx   = min_idx_q;

endmodule

// File: tb/tb_dual_mode_peak_tracker.sv
// Scoreboard bench for dual_mode_peak_tracker: each run pushes its expected result,
// a monitor pops and compares whenever done_tick fires.
module tb_dual_mode_peak_tracker;

  localparam int unsigned W  = 8;
  localparam int unsigned LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [LW-1:0] len = '0;
  logic [W-1:0]  din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [W-1:0]  max_val, min_val;
  logic [LW-1:0] max_idx, min_idx;
  logic          busy, done_tick, empty;

  typedef struct {
    logic [W-1:0]  mx;
    logic [W-1:0]  mn;
    logic [LW-1:0] mxi;
    logic [LW-1:0] mni;
    logic          emp;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         last_exp;
  logic [W-1:0] samp [256];
  int           n_cmp = 0;
  int           n_err = 0;

  dual_mode_peak_tracker #(.W(W), .LW(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .len       (len),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .max_val   (max_val),
    .min_val   (min_val),
    .max_idx   (max_idx),
    .min_idx   (min_idx),
    .busy      (busy),
    .done_tick (done_tick),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit greater(input logic [W-1:0] a, input logic [W-1:0] b, input bit m);
    if (m) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  // Monitor: every done_tick must match the oldest pending expectation
  always @(negedge clk) begin
    if (done_tick) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", 32'(done_tick), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("max_val", 32'(max_val), 32'(e.mx));
        check_eq("min_val", 32'(min_val), 32'(e.mn));
        check_eq("max_idx", 32'(max_idx), 32'(e.mxi));
        check_eq("min_idx", 32'(min_idx), 32'(e.mni));
        check_eq("empty",   32'(empty),   32'(e.emp));
        check_eq("busy_in_done", 32'(busy), 32'd0);
        last_exp = e;
      end
    end
  end

  // gap < 0 picks a random 0..3 idle cycles before each sample
  task automatic run_case(input bit m, input int n, input int gap, input bit disturb);
    exp_t e;
    e.mx = '0; e.mn = '0; e.mxi = '0; e.mni = '0; e.emp = (n == 0);
    for (int i = 0; i < n; i++) begin
      if (i == 0 || greater(samp[i], e.mx, m)) begin e.mx = samp[i]; e.mxi = LW'(i); end
      if (i == 0 || greater(e.mn, samp[i], m)) begin e.mn = samp[i]; e.mni = LW'(i); end
    end
    sb_q.push_back(e);

    @(posedge clk); #1;
    start = 1'b1; mode = m; len = LW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      for (int k = 0; k < g; k++) begin
        din_valid = 1'b0;
        din = W'($urandom);
        if (disturb) begin
          start = 1'b1; mode = ~m; len = LW'($urandom_range(0, 3));
        end
        @(posedge clk); #1;
      end
      start = 1'b0;
      din = samp[i]; din_valid = 1'b1;
      @(negedge clk);
      check_eq("din_ready_active", 32'(din_ready), 32'd1);
      @(posedge clk); #1;
      din_valid = 1'b0;
    end
    // One cycle after the last accepted sample (or the start for len=0)
    @(negedge clk);
    check_eq("done_latency", 32'(done_tick), 32'd1);
    if (n == 0) check_eq("din_ready_len0", 32'(din_ready), 32'd0);
    for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    // Results hold in IDLE
    repeat (3) @(negedge clk);
    check_eq("hold_max", 32'(max_val), 32'(last_exp.mx));
    check_eq("hold_min_idx", 32'(min_idx), 32'(last_exp.mni));
    check_eq("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_din_ready"}, 32'(din_ready), 32'd0);
    check_eq({tag, "_busy"},      32'(busy),      32'd0);
    check_eq({tag, "_done"},      32'(done_tick), 32'd0);
    check_eq({tag, "_empty"},     32'(empty),     32'd0);
    check_eq({tag, "_max"},       32'(max_val),   32'd0);
    check_eq({tag, "_min"},       32'(min_val),   32'd0);
    check_eq({tag, "_max_idx"},   32'(max_idx),   32'd0);
    check_eq({tag, "_min_idx"},   32'(min_idx),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // Unsigned 0x80, 0x7F, 0x01
    samp[0] = 8'h80; samp[1] = 8'h7F; samp[2] = 8'h01;
    run_case(1'b0, 3, 0, 1'b0);
    // Signed, same samples
    run_case(1'b1, 3, 0, 1'b0);

    // Ties keep first index, stalls between samples
    samp[0] = 8'd5; samp[1] = 8'd9; samp[2] = 8'd9; samp[3] = 8'd2;
    run_case(1'b0, 4, 2, 1'b0);

    // Zero-length run
    run_case(1'b0, 0, 0, 1'b0);

    // Mode toggle and start during ACTIVE ignored
    samp[0] = 8'hF0; samp[1] = 8'h10; samp[2] = 8'h90; samp[3] = 8'h7E;
    run_case(1'b1, 4, 1, 1'b1);
    run_case(1'b0, 4, 2, 1'b1);

    // Mid-run reset with start and valid also asserted
    for (int i = 0; i < 5; i++) samp[i] = W'(8'h30 + i);
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b0; len = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      din = samp[i]; din_valid = 1'b1;
      @(posedge clk); #1;
    end
    din = samp[2]; din_valid = 1'b1; start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; din_valid = 1'b0;
    @(negedge clk);
    check_zero("midrun_rst");
    repeat (6) @(negedge clk);
    check_eq("post_rst_busy", 32'(busy), 32'd0);

    samp[0] = 8'hAA;
    run_case(1'b0, 1, 0, 1'b0);

    // Longest run: indices reach 254 without wrap
    for (int i = 0; i < 254; i++) samp[i] = W'(i + 1);
    samp[254] = 8'h00;
    run_case(1'b0, 255, 0, 1'b0);

    // Random runs
    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) samp[i] = W'($urandom);
      run_case(1'($urandom_range(0, 1)), n, -1, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dual_mode_peak_tracker.md
DUAL_MODE_PEAK_TRACKER -- requirements
Module: dual_mode_peak_tracker

Interface
REQ-001 SHALL have parameter W, default 8, sample width in bits.
REQ-002 SHALL have parameter LW, default 8, width of the run length and index.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request to begin a run; sampled only in IDLE.
REQ-006 SHALL have port mode, input, 1, compare mode: 1 = two's-complement signed, 0 = unsigned; sampled with start.
REQ-007 SHALL have port len, input, LW, number of samples in the run; sampled with start.
REQ-008 SHALL have port din, input, W, sample data.
REQ-009 SHALL have port din_valid, input, 1, din is valid this cycle.
REQ-010 SHALL have port din_ready, output, 1, block accepts a sample this cycle.
REQ-011 SHALL have port max_val, output, W, largest sample of the last completed run.
REQ-012 SHALL have port min_val, output, W, smallest sample of the last completed run.
REQ-013 SHALL have port max_idx, output, LW, zero-based position of max_val within the run.
REQ-014 SHALL have port min_idx, output, LW, zero-based position of min_val within the run.
REQ-015 SHALL have port busy, output, 1, high in ACTIVE.
REQ-016 SHALL have port done_tick, output, 1, one-cycle pulse when results become valid.
REQ-017 SHALL have port empty, output, 1, last completed run had len = 0.

Function
REQ-018 SHALL implement three states: IDLE, ACTIVE, DONE.
REQ-019 IDLE: start=1 with len>0 SHALL latch mode and len, clear the sample counter, and go to ACTIVE; start=1 with len=0 SHALL go to DONE with empty=1.
REQ-020 din_ready SHALL equal 1 only in ACTIVE; a sample is accepted on a cycle with din_valid=1 and din_ready=1.
REQ-021 The first accepted sample SHALL load both running max and min and set both indices to 0.
REQ-022 Each later sample SHALL replace the running max only if strictly greater, and the running min only if strictly less, under the latched mode; on ties the earlier index is retained.
REQ-023 Signed mode SHALL compare samples as W-bit two's complement; unsigned mode SHALL compare them as magnitudes.
REQ-024 Changes to mode or len during ACTIVE SHALL have no effect on the current run.
REQ-025 Accepting sample number len SHALL move the FSM to DONE on the next edge; max_val, min_val, max_idx and min_idx SHALL be valid from that cycle.
REQ-026 DONE SHALL last exactly one cycle, with done_tick=1, then return to IDLE.
REQ-027 Results and empty SHALL hold unchanged in IDLE until the next run reaches DONE.
REQ-028 start SHALL be ignored in ACTIVE and DONE.
REQ-029 Cycles with din_valid=0 in ACTIVE SHALL stall the run without altering state.
REQ-030 For len = 2^LW-1, indices SHALL reach 2^LW-2 without wrap.
REQ-031 A zero-length run SHALL set max_val, min_val, max_idx and min_idx to 0.
REQ-032 Latency from the last accepted sample to done_tick SHALL be one cycle.

Reset
REQ-033 rst=1 SHALL on the next edge force IDLE and zero every output: din_ready, busy, done_tick, empty, max_val, min_val, max_idx, min_idx.
REQ-034 rst SHALL take priority over start and over sample acceptance, including mid-run; the partial run is discarded and no done_tick is produced.

Verification
REQ-035 Unsigned, len=3, samples 0x80, 0x7F, 0x01 -> done_tick one cycle after the third sample; max=0x80 idx0, min=0x01 idx2.
REQ-036 Signed, len=3, same samples -> max=0x7F idx1, min=0x80 idx0.
REQ-037 Unsigned, len=4, samples 5, 9, 9, 2 with din_valid low for 2 cycles between samples -> max=9 idx1 (tie keeps first), min=2 idx3; done_tick one cycle after the last sample.
REQ-038 start with len=0 -> done_tick and empty=1 one cycle later; all results 0; din_ready never high.
REQ-039 rst asserted after 2 of 5 samples -> all outputs 0 next cycle, no done_tick; a new run of len=1 with sample 0xAA -> max=min=0xAA, both indices 0.
REQ-040 mode toggled and start pulsed during ACTIVE -> both ignored; results match the mode latched at the original start.
